branch_predict_unit: RTL and testbench

Parametrised successor to the CPU's combinational branch/jump resolver. Adds a fetch-side prediction path (direct-mapped 2-bit BHT plus tagged BTB) and a resolve-side checker. The checker evaluates the existing 3-bit condition codes against the Z/N/V flags, detects mispredictions and issues a registered redirect. It also maintains a return-address stack (RAS) for call and return jumps. It sits between fetch (lookup) and execute (resolve).

---
 rtl/branch_predict_unit_if.sv | 44 ++++
 rtl/branch_predict_unit.sv | 181 ++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch lookup and execute resolve bundle for the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predict_unit_if #(
  parameter int PC_W = 16
);
  logic [PC_W-1:0] f_pc;
  logic            f_pred_taken;
  logic [PC_W-1:0] f_pred_target;

  logic            r_valid;
  logic            r_branch;
  logic            r_jump;
  logic            r_link;
  logic            r_ret;
  logic [2:0]      r_cond;
  logic [2:0]      r_flags;
  logic [PC_W-1:0] r_pc_plus_one;
  logic [PC_W-1:0] r_offset;
  logic            r_pred_taken;
  logic [PC_W-1:0] r_pred_target;

  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] link_addr;
  logic            ras_underflow;

  modport master (
    output f_pc,
    input  f_pred_taken, f_pred_target,
    output r_valid, r_branch, r_jump, r_link, r_ret,
    output r_cond, r_flags, r_pc_plus_one, r_offset,
    output r_pred_taken, r_pred_target,
    input  mispredict, redirect_pc, link_addr, ras_underflow
  );

  modport slave (
    input  f_pc,
    output f_pred_taken, f_pred_target,
    input  r_valid, r_branch, r_jump, r_link, r_ret,
    input  r_cond, r_flags, r_pc_plus_one, r_offset,
    input  r_pred_taken, r_pred_target,
    output mispredict, redirect_pc, link_addr, ras_underflow
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit BHT + tagged BTB lookup, resolve checker
// with registered redirect, and a circular return-address stack.
module branch_predict_unit #(
  parameter int PC_W      = 16,
  parameter int IDX_W     = 4,
  parameter int RAS_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  branch_predict_unit_if.slave bp
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [1:0]       bht_q     [DEPTH];
  logic [DEPTH-1:0] btb_vld_q;
  logic [DEPTH-1:0] btb_jmp_q;
  logic [TAG_W-1:0] btb_tag_q [DEPTH];
  logic [PC_W-1:0]  btb_tgt_q [DEPTH];

  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;

  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;
  logic [PC_W-1:0]  link_q, link_d;
  logic             uf_q, uf_d;

  // Fetch-side lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken;

  assign f_idx   = bp.f_pc[IDX_W-1:0];
  assign f_tag   = bp.f_pc[PC_W-1:IDX_W];
  assign f_hit   = btb_vld_q[f_idx] & (btb_tag_q[f_idx] == f_tag);
  assign f_taken = f_hit & (btb_jmp_q[f_idx] | bht_q[f_idx][1]);

  assign bp.f_pred_taken  = f_taken;
  assign bp.f_pred_target = f_taken ? btb_tgt_q[f_idx]
                                    : bp.f_pc + PC_W'(1);

  // Resolve-side decode
  logic             z_f, n_f, v_f;
  logic             taken_b;
  logic             is_br, is_jmp;
  logic             ras_empty;
  logic [PTR_W-1:0] ptr_m1;
  logic [PC_W-1:0]  ras_top;
  logic [PC_W-1:0]  sum;
  logic [PC_W-1:0]  target;
  logic             act_taken;
  logic [PC_W-1:0]  act_next;
  logic [PC_W-1:0]  rpc;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic [1:0]       bht_nxt;

  assign z_f = bp.r_flags[2];
  assign n_f = bp.r_flags[1];
  assign v_f = bp.r_flags[0];

  always_comb begin
    taken_b = 1'b0;
    unique case (bp.r_cond)
      3'd0: taken_b = 1'b1;
      3'd1: taken_b = z_f;
      3'd2: taken_b = ~z_f;
      3'd3: taken_b = ~(z_f | n_f);
      3'd4: taken_b = ~n_f;
      3'd5: taken_b = n_f;
      3'd6: taken_b = n_f | z_f;
      3'd7: taken_b = v_f;
    endcase
  end

  // Branch wins when both branch and jump are flagged
  assign is_br  = bp.r_valid & bp.r_branch;
  assign is_jmp = bp.r_valid & bp.r_jump & ~bp.r_branch;

  assign ras_empty = (ras_cnt_q == '0);
  assign ptr_m1    = ras_ptr_q - PTR_W'(1);
  assign ras_top   = ras_q[ptr_m1];
  assign sum       = bp.r_pc_plus_one + bp.r_offset;

  assign target    = (is_jmp & bp.r_ret & ~ras_empty) ? ras_top : sum;
  assign act_taken = is_jmp | (is_br & taken_b);
  assign act_next  = act_taken ? target : bp.r_pc_plus_one;

  assign rpc   = bp.r_pc_plus_one - PC_W'(1);
  assign r_idx = rpc[IDX_W-1:0];
  assign r_tag = rpc[PC_W-1:IDX_W];

  always_comb begin
    bht_nxt = bht_q[r_idx];
    if (taken_b) begin
      if (bht_q[r_idx] != 2'd3) bht_nxt = bht_q[r_idx] + 2'd1;
    end else begin
      if (bht_q[r_idx] != 2'd0) bht_nxt = bht_q[r_idx] - 2'd1;
    end
  end

  always_comb begin
    mispredict_d = bp.r_valid &
                   ((act_taken != bp.r_pred_taken) |
                    (act_taken & (target != bp.r_pred_target)));
    redirect_d   = bp.r_valid ? act_next : redirect_q;
    uf_d         = is_jmp & bp.r_ret & ras_empty;
    link_d       = (is_jmp & bp.r_link) ? bp.r_pc_plus_one : link_q;
  end

  // RAS: ret+link on a non-empty stack replaces the top in place
  logic             ras_we;
  logic [PTR_W-1:0] ras_wa;

  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_wa    = ras_ptr_q;
    if (is_jmp) begin
      if (bp.r_ret & bp.r_link & ~ras_empty) begin
        ras_we = 1'b1;
        ras_wa = ptr_m1;
      end else begin
        if (bp.r_ret & ~ras_empty) begin
          ras_ptr_d = ptr_m1;
          ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
        if (bp.r_link) begin
          ras_we    = 1'b1;
          ras_wa    = ras_ptr_q;
          ras_ptr_d = ras_ptr_q + PTR_W'(1);
          if (ras_cnt_q != RAS_FULL)
            ras_cnt_d = ras_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= 2'b01;
      btb_vld_q    <= '0;
      btb_jmp_q    <= '0;
      ras_ptr_q    <= '0;
      ras_cnt_q    <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      link_q       <= '0;
      uf_q         <= 1'b0;
    end else begin
      ras_ptr_q    <= ras_ptr_d;
      ras_cnt_q    <= ras_cnt_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      link_q       <= link_d;
      uf_q         <= uf_d;
      if (is_br) bht_q[r_idx] <= bht_nxt;
      if (act_taken) begin
        btb_vld_q[r_idx] <= 1'b1;
        btb_jmp_q[r_idx] <= is_jmp;
        btb_tag_q[r_idx] <= r_tag;
        btb_tgt_q[r_idx] <= target;
      end
      if (ras_we) ras_q[ras_wa] <= bp.r_pc_plus_one;
    end
  end

  assign bp.mispredict    = mispredict_q;
  assign bp.redirect_pc   = redirect_q;
  assign bp.link_addr     = link_q;
  assign bp.ras_underflow = uf_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a reference model predicts
// lookups and the registered resolve outputs one cycle later.
module tb_branch_predict_unit;

  localparam int PC_W      = 16;
  localparam int IDX_W     = 4;
  localparam int RAS_DEPTH = 4;
  localparam int DEPTH     = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(PC_W)) bp_if ();

  branch_predict_unit #(
    .PC_W(PC_W), .IDX_W(IDX_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  bit armed = 1'b0;

  typedef struct {
    int          cyc;
    bit          mp;
    bit          chk_rd;
    logic [15:0] rd;
    bit          uf;
    logic [15:0] la;
    string       tag;
  } exp_t;

  exp_t sb[$];

  int          m_bht [DEPTH];
  bit          m_v   [DEPTH];
  bit          m_j   [DEPTH];
  logic [11:0] m_tag [DEPTH];
  logic [15:0] m_tgt [DEPTH];
  logic [15:0] m_ras [$];
  logic [15:0] m_la;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(logic [2:0] c, logic [2:0] f);
    bit z, n, v;
    z = f[2]; n = f[1]; v = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !z && !n;
      3'd4: return !n;
      3'd5: return n;
      3'd6: return n || z;
      default: return v;
    endcase
  endfunction

  function automatic void m_pred(input logic [15:0] pc,
                                 output bit tk,
                                 output logic [15:0] tg);
    int i;
    bit hit;
    i   = int'(pc[3:0]);
    hit = m_v[i] && (m_tag[i] == pc[15:4]);
    tk  = hit && (m_j[i] || m_bht[i] >= 2);
    tg  = tk ? m_tgt[i] : pc + 16'd1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_bht[i] = 1;
      m_v[i]   = 1'b0;
      m_j[i]   = 1'b0;
    end
    m_ras.delete();
    m_la = 16'h0;
  endfunction

  task automatic chk_lookup(string tag);
    bit          tk;
    logic [15:0] tg;
    m_pred(bp_if.f_pc, tk, tg);
    chk({tag, ".ptk"}, bp_if.f_pred_taken, tk);
    chk({tag, ".ptg"}, bp_if.f_pred_target, tg);
  endtask

  task automatic lookup(logic [15:0] pc, string tag);
    bp_if.f_pc = pc;
    #1;
    chk_lookup(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.push_back('{cyc + 1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0, "rst"});
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bp_if.r_valid = 1'b0;
    armed = 1'b1;
  endtask

  task automatic resolve(bit br, bit jmp, bit link, bit ret,
                         logic [2:0] cond, logic [2:0] flags,
                         logic [15:0] pc1, logic [15:0] off,
                         bit pt, logic [15:0] ptg, string tag);
    bit          j, at, mp, uf;
    logic [15:0] tgt, nx, rp;
    int          i;
    bp_if.r_valid       = 1'b1;
    bp_if.r_branch      = br;
    bp_if.r_jump        = jmp;
    bp_if.r_link        = link;
    bp_if.r_ret         = ret;
    bp_if.r_cond        = cond;
    bp_if.r_flags       = flags;
    bp_if.r_pc_plus_one = pc1;
    bp_if.r_offset      = off;
    bp_if.r_pred_taken  = pt;
    bp_if.r_pred_target = ptg;
    rp = pc1 - 16'd1;
    bp_if.f_pc = rp;
    #1;
    chk_lookup({tag, ".old"});

    j  = jmp && !br;
    uf = j && ret && (m_ras.size() == 0);
    if (j && ret && m_ras.size() > 0) tgt = m_ras[m_ras.size() - 1];
    else tgt = pc1 + off;
    at = j || (br && cond_ok(cond, flags));
    nx = at ? tgt : pc1;
    mp = (at != pt) || (at && tgt != ptg);

    i = int'(rp[3:0]);
    if (br) begin
      if (cond_ok(cond, flags)) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
      else m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
    end
    if (at) begin
      m_v[i]   = 1'b1;
      m_j[i]   = j;
      m_tag[i] = rp[15:4];
      m_tgt[i] = tgt;
    end
    if (j) begin
      if (ret && link && m_ras.size() > 0) begin
        m_ras[m_ras.size() - 1] = pc1;
      end else begin
        if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
        if (link) begin
          if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(pc1);
        end
      end
      if (link) m_la = pc1;
    end

    sb.push_back('{cyc + 1, mp, mp, nx, uf, m_la, tag});
    @(posedge clk);
    #1;
    bp_if.r_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk({e.tag, ".mp"}, bp_if.mispredict, e.mp);
        if (e.chk_rd) chk({e.tag, ".rd"}, bp_if.redirect_pc, e.rd);
        chk({e.tag, ".uf"}, bp_if.ras_underflow, e.uf);
        chk({e.tag, ".la"}, bp_if.link_addr, e.la);
      end else begin
        chk("idle.mp", bp_if.mispredict, 1'b0);
        chk("idle.uf", bp_if.ras_underflow, 1'b0);
      end
    end
  end

  initial begin
    bit          tk;
    logic [15:0] tg;
    bp_if.f_pc          = '0;
    bp_if.r_valid       = 1'b0;
    bp_if.r_branch      = 1'b0;
    bp_if.r_jump        = 1'b0;
    bp_if.r_link        = 1'b0;
    bp_if.r_ret         = 1'b0;
    bp_if.r_cond        = '0;
    bp_if.r_flags       = '0;
    bp_if.r_pc_plus_one = '0;
    bp_if.r_offset      = '0;
    bp_if.r_pred_taken  = 1'b0;
    bp_if.r_pred_target = '0;

    // Basic U-branch training
    do_reset();
    lookup(16'h0005, "rst5");
    chk("rst5.const", bp_if.f_pred_target, 16'h0006);
    resolve(1, 0, 0, 0, 3'd0, 3'd0, 16'h0006, 16'h0010, 0, 16'h0, "ubr");
    lookup(16'h0005, "trained5");
    chk("trained5.tk", bp_if.f_pred_taken, 1'b1);
    chk("trained5.tg", bp_if.f_pred_target, 16'h0016);

    // Condition sweep, back-to-back
    do_reset();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        resolve(1, 0, 0, 0, 3'(c), 3'(f), 16'(16'h0200 + c * 8 + f),
                16'h0020, 0, 16'h0, "cond");

    // Counter saturation on PC 0x0003
    do_reset();
    for (int k = 0; k < 4; k++)
      resolve(1, 0, 0, 0, 3'd0, 3'd0, 16'h0004, 16'h0008, 0, 16'h0, "sat_t");
    lookup(16'h0003, "sat3");
    resolve(1, 0, 0, 0, 3'd1, 3'd0, 16'h0004, 16'h0008, 1, 16'h000c, "sat_n");
    lookup(16'h0003, "sat2");
    chk("sat2.tk", bp_if.f_pred_taken, 1'b1);
    for (int k = 0; k < 3; k++)
      resolve(1, 0, 0, 0, 3'd1, 3'd0, 16'h0004, 16'h0008, 0, 16'h0, "sat_n");
    lookup(16'h0003, "sat0");
    chk("sat0.tk", bp_if.f_pred_taken, 1'b0);

    // Aliasing: same index, different tag
    do_reset();
    resolve(1, 0, 0, 0, 3'd0, 3'd0, 16'h0014, 16'h0040, 0, 16'h0, "alias");
    lookup(16'h0023, "alias23");
    chk("alias23.tg", bp_if.f_pred_target, 16'h0024);
    lookup(16'h0013, "alias13");

    // RAS overflow then underflow
    do_reset();
    for (int k = 0; k < 5; k++)
      resolve(0, 1, 1, 0, 3'd0, 3'd0, 16'(16'h0100 + k), 16'h0050,
              0, 16'h0, "call");
    for (int k = 0; k < 5; k++)
      resolve(0, 1, 0, 1, 3'd0, 3'd0, 16'(16'h0300 + k), 16'h0000,
              0, 16'h0, "ret");

    // Branch+jump+ret: branch wins, RAS untouched
    do_reset();
    resolve(0, 1, 1, 0, 3'd0, 3'd0, 16'h0400, 16'h0010, 1, 16'h0410, "call1");
    resolve(1, 1, 0, 1, 3'd1, 3'd0, 16'h0500, 16'h0010, 1, 16'h0510, "brj_p1");
    resolve(1, 1, 0, 1, 3'd1, 3'd0, 16'h0500, 16'h0010, 0, 16'h0000, "brj_p0");
    resolve(0, 1, 0, 1, 3'd0, 3'd0, 16'h0600, 16'h0000, 1, 16'h0400, "ret1");
    resolve(0, 1, 1, 1, 3'd0, 3'd0, 16'h0700, 16'h0000, 0, 16'h0, "retcall");

    // Reset during a resolve discards it
    bp_if.r_valid       = 1'b1;
    bp_if.r_branch      = 1'b1;
    bp_if.r_cond        = 3'd0;
    bp_if.r_pc_plus_one = 16'h0030;
    bp_if.r_offset      = 16'h0005;
    bp_if.r_pred_taken  = 1'b0;
    do_reset();
    lookup(16'h002f, "rstmid");
    chk("rstmid.tk", bp_if.f_pred_taken, 1'b0);

    // Random mix with aliasing and RAS traffic
    for (int k = 0; k < 300; k++) begin
      logic [15:0] pc1;
      bit          br, jmp;
      pc1 = 16'($urandom_range(1, 70));
      br  = ($urandom_range(0, 2) == 0);
      jmp = ($urandom_range(0, 1) == 1);
      m_pred(pc1 - 16'd1, tk, tg);
      if ($urandom_range(0, 3) == 0) begin
        tk = 1'($urandom);
        tg = 16'($urandom_range(0, 127));
      end
      resolve(br, jmp, 1'($urandom), 1'($urandom),
              3'($urandom), 3'($urandom), pc1,
              16'($urandom_range(0, 31)), tk, tg, "rnd");
      if (k % 16 == 0) lookup(16'($urandom_range(0, 70)), "rndlk");
    end

    bp_if.r_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
